// File: rtl/led_shift_pkg.sv
// Shared types and helpers for the LED shift-out block.
package led_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_e;

  // Cycles busy stays high for one frame: LOAD + WIDTH bit periods + latch pulse.
  function automatic int frame_cycles(input int width, input int div);
    return 1 + 2 * div * width + div;
  endfunction

endpackage

// File: rtl/led_serializer.sv
// Serialises a WIDTH-bit snapshot onto a 74HC595-style chain (clock, data, latch).
// state | meaning
// IDLE  | waiting for start_i; done_o pulses in the first cycle after a frame
// LOAD  | snapshot data_i, present the first bit with led_clk low
// SHIFT | per bit: CLK_DIV cycles low then CLK_DIV cycles high
// LATCH | led_pen high for CLK_DIV cycles, then back to IDLE
module led_serializer
  import led_shift_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             led_clk_o,
  output logic             led_pen_o,
  output logic             led_dat_o
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shadow_q;
  logic [BW-1:0]    bit_q;
  logic [DW-1:0]    div_q;
  logic             busy_q, done_q, clk_q, pen_q, dat_q;

  // The bit counter always runs down; bit order only changes which bit it selects.
  function automatic logic pick(input logic [WIDTH-1:0] v, input logic [BW-1:0] b);
    if (MSB_FIRST) return v[b];
    else           return v[BIT_LAST - b];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clk_q    <= 1'b0;
      pen_q    <= 1'b0;
      dat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          shadow_q <= data_i;
          dat_q    <= pick(data_i, BIT_LAST);
          bit_q    <= BIT_LAST;
          div_q    <= DIV_LAST;
          clk_q    <= 1'b0;
          state_q  <= SHIFT;
        end
        SHIFT: begin
          if (div_q != '0) begin
            div_q <= div_q - DW'(1);
          end else begin
            div_q <= DIV_LAST;
            if (!clk_q) begin
              clk_q <= 1'b1;
            end else begin
              clk_q <= 1'b0;
              if (bit_q == '0) begin
                state_q <= LATCH;
                pen_q   <= 1'b1;
              end else begin
                bit_q <= bit_q - BW'(1);
                dat_q <= pick(shadow_q, bit_q - BW'(1));
              end
            end
          end
        end
        LATCH: begin
          if (div_q != '0) begin
            div_q <= div_q - DW'(1);
          end else begin
            pen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign led_clk_o = clk_q;
  assign led_pen_o = pen_q;
  assign led_dat_o = dat_q;

endmodule

// File: rtl/led_shift_out.sv
// LED image register with bit-masked writes; pushes the image out serially
// after each write (or continuously when REFRESH is set).
module led_shift_out
  import led_shift_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit REFRESH   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] wmask,
  input  logic [WIDTH-1:0] led_in,
  output logic [WIDTH-1:0] led_out,
  output logic             busy,
  output logic             done,
  output logic             led_clk,
  output logic             led_pen,
  output logic             led_dat
);

  logic [WIDTH-1:0] led_q, led_d;
  logic             pending_q, pending_d;
  logic             busy_prev_q;
  logic             load_cycle;
  logic             start;

  // busy rises on entry to LOAD, so its first cycle marks the snapshot.
  assign load_cycle = busy & ~busy_prev_q;
  assign start      = (pending_q | REFRESH) & ~busy;

  always_comb begin
    led_d     = led_q;
    pending_d = pending_q;
    if (load_cycle) pending_d = 1'b0;
    if (we) begin
      led_d     = (led_q & ~wmask) | (led_in & wmask);
      pending_d = 1'b1;
    end
  end

  // Reset leaves pending set so the external chain is cleared with zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= '0;
      pending_q   <= 1'b1;
      busy_prev_q <= 1'b0;
    end else begin
      led_q       <= led_d;
      pending_q   <= pending_d;
      busy_prev_q <= busy;
    end
  end

  led_serializer #(
    .WIDTH    (WIDTH),
    .CLK_DIV  (CLK_DIV),
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .data_i   (led_q),
    .busy_o   (busy),
    .done_o   (done),
    .led_clk_o(led_clk),
    .led_pen_o(led_pen),
    .led_dat_o(led_dat)
  );

  assign led_out = led_q;

endmodule

// File: tb/tb_led_shift_out.sv
// Scoreboard bench: stimulus queues expected frame words, monitors rebuild
// each frame from the serial pins and compare on done.
module tb_led_shift_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Main (MSB first) and LSB-first instances share stimulus.
  logic        rst = 1'b1, we = 1'b0;
  logic [15:0] wmask = '0, led_in = '0;
  logic [15:0] m_out, l_out;
  logic        m_busy, m_done, m_clk, m_pen, m_dat;
  logic        l_busy, l_done, l_clk, l_pen, l_dat;

  led_shift_out #(.WIDTH(16), .CLK_DIV(2), .MSB_FIRST(1'b1), .REFRESH(1'b0)) u_main (
    .clk(clk), .rst(rst), .we(we), .wmask(wmask), .led_in(led_in), .led_out(m_out),
    .busy(m_busy), .done(m_done), .led_clk(m_clk), .led_pen(m_pen), .led_dat(m_dat));

  led_shift_out #(.WIDTH(16), .CLK_DIV(2), .MSB_FIRST(1'b0), .REFRESH(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .we(we), .wmask(wmask), .led_in(led_in), .led_out(l_out),
    .busy(l_busy), .done(l_done), .led_clk(l_clk), .led_pen(l_pen), .led_dat(l_dat));

  logic       r_rst = 1'b1, r_we = 1'b0;
  logic [7:0] r_wmask = '0, r_in = '0, r_out;
  logic       r_busy, r_done, r_clk, r_pen, r_dat;

  led_shift_out #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b1), .REFRESH(1'b1)) u_ref (
    .clk(clk), .rst(r_rst), .we(r_we), .wmask(r_wmask), .led_in(r_in), .led_out(r_out),
    .busy(r_busy), .done(r_done), .led_clk(r_clk), .led_pen(r_pen), .led_dat(r_dat));

  logic [15:0] q_m[$], q_l[$];
  logic [7:0]  q_r[$];

  // Main monitor
  logic [15:0] m_word = '0;
  int m_rises = 0, m_pen_len = 0, m_busy_len = 0, m_frames = 0, m_pen_pulses = 0;
  logic m_clk_prev = 1'b0, m_pen_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      m_word = '0; m_rises = 0; m_pen_len = 0; m_busy_len = 0;
      m_clk_prev = 1'b0; m_pen_prev = 1'b0;
    end else begin
      if (m_clk && !m_clk_prev) begin m_word = {m_word[14:0], m_dat}; m_rises++; end
      if (m_pen && !m_pen_prev) m_pen_pulses++;
      if (m_pen) m_pen_len++;
      if (m_busy) m_busy_len++;
      if (m_done) begin
        m_frames++;
        if (q_m.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL main_extra_frame: got frame %h expected none", m_word);
        end else begin
          check("main_word", m_word, q_m.pop_front());
          check("main_rises", m_rises, 16);
          check("main_pen_len", m_pen_len, 2);
          check("main_busy_len", m_busy_len, 67);
        end
        m_word = '0; m_rises = 0; m_pen_len = 0; m_busy_len = 0;
      end
      m_clk_prev = m_clk; m_pen_prev = m_pen;
    end
  end

  // LSB-first monitor: the first bit out lands in the MSB of l_word.
  logic [15:0] l_word = '0;
  int l_rises = 0, l_frames = 0;
  logic l_clk_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      l_word = '0; l_rises = 0; l_clk_prev = 1'b0;
    end else begin
      if (l_clk && !l_clk_prev) begin l_word = {l_word[14:0], l_dat}; l_rises++; end
      if (l_done) begin
        l_frames++;
        if (q_l.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL lsb_extra_frame: got frame %h expected none", l_word);
        end else begin
          check("lsb_word", l_word, q_l.pop_front());
          check("lsb_rises", l_rises, 16);
        end
        l_word = '0; l_rises = 0;
      end
      l_clk_prev = l_clk;
    end
  end

  // Refresh monitor: checks only while armed by the stimulus.
  logic [7:0] r_word = '0;
  int r_rises = 0, r_since = 0, r_idle = 0;
  logic r_clk_prev = 1'b0, r_armed = 1'b0;
  always @(negedge clk) begin
    if (r_rst) begin
      r_word = '0; r_rises = 0; r_since = 0; r_idle = 0; r_clk_prev = 1'b0;
    end else begin
      r_since++;
      if (!r_busy) r_idle++;
      if (r_clk && !r_clk_prev) begin r_word = {r_word[6:0], r_dat}; r_rises++; end
      if (r_done) begin
        if (r_armed && q_r.size() != 0) begin
          check("ref_word", r_word, q_r.pop_front());
          check("ref_rises", r_rises, 8);
          check("ref_period", r_since, 19);
          check("ref_busy_low", r_idle, 1);
        end
        r_word = '0; r_rises = 0; r_since = 0; r_idle = 0;
      end
      r_clk_prev = r_clk;
    end
  end

  task automatic wait_done(input bit use_ref, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(use_ref ? r_done : m_done) && n < budget);
    if (!(use_ref ? r_done : m_done)) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic do_write(input logic [15:0] m, input logic [15:0] d);
    @(posedge clk); #1;
    we = 1'b1; wmask = m; led_in = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_led_out", m_out, 16'h0000);
    check("reset_outputs", {m_busy, m_done, m_clk, m_pen, m_dat}, 5'b0);
    // 1: zero frame after reset release
    q_m.push_back(16'h0000); q_l.push_back(16'h0000);
    rst = 1'b0; r_rst = 1'b0;
    wait_done(1'b0, 200, "t1_done");
    repeat (100) @(posedge clk);

    // 2: full write
    q_m.push_back(16'hA5C3); q_l.push_back(16'hC3A5);
    do_write(16'hFFFF, 16'hA5C3);
    check("t2_led_out", m_out, 16'hA5C3);
    wait_done(1'b0, 200, "t2_done");

    // 3: masked write
    q_m.push_back(16'hA534); q_l.push_back(16'h2CA5);
    do_write(16'h00FF, 16'h1234);
    check("t3_led_out", m_out, 16'hA534);
    wait_done(1'b0, 200, "t3_done");

    // 4: two writes mid-frame produce one follow-up frame
    q_m.push_back(16'hA5C3); q_l.push_back(16'hC3A5);
    do_write(16'hFFFF, 16'hA5C3);
    repeat (18) @(posedge clk);
    q_m.push_back(16'hFFFF); q_l.push_back(16'hFFFF);
    #1; we = 1'b1; wmask = 16'hFFFF; led_in = 16'h0F0F;
    @(posedge clk); #1; led_in = 16'hFFFF;
    @(posedge clk); #1; we = 1'b0;
    check("t4_led_out", m_out, 16'hFFFF);
    wait_done(1'b0, 200, "t4_done_a");
    wait_done(1'b0, 200, "t4_done_b");
    repeat (100) @(posedge clk);

    // 5: reset mid-frame aborts, then a zero frame follows
    do_write(16'hFFFF, 16'hA5C3);
    repeat (22) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("t5_led_out", m_out, 16'h0000);
    check("t5_outputs", {m_busy, m_done, m_clk, m_pen, m_dat}, 5'b0);
    q_m.push_back(16'h0000); q_l.push_back(16'h0000);
    wait_done(1'b0, 200, "t5_done");
    repeat (100) @(posedge clk);

    check("main_frames", m_frames, 6);
    check("main_pen_pulses", m_pen_pulses, 6);
    check("lsb_frames", l_frames, 6);
    check("main_queue_empty", q_m.size(), 0);
    check("lsb_queue_empty", q_l.size(), 0);

    // 6: continuous refresh of 3C
    @(posedge clk); #1;
    r_we = 1'b1; r_wmask = 8'hFF; r_in = 8'h3C;
    @(posedge clk); #1; r_we = 1'b0;
    check("t6_led_out", r_out, 8'h3C);
    wait_done(1'b1, 50, "t6_sync_a");
    wait_done(1'b1, 50, "t6_sync_b");
    for (int i = 0; i < 5; i++) q_r.push_back(8'h3C);
    r_armed = 1'b1;
    for (int i = 0; i < 5; i++) wait_done(1'b1, 50, "t6_done");
    @(posedge clk);
    r_armed = 1'b0;
    check("ref_queue_empty", q_r.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_shift_out.md
Name: led_shift_out

Overview:
- Parametrised successor to the board LED output register.
- Holds a WIDTH-bit LED image written by the CPU/bus through a bit-masked write port.
- Serialises the image to an external shift-register chain (74HC595-style) over led_clk/led_dat/led_pen.
- Adds what the fixed 16-bit version lacks: configurable width, serial clock divider, bit order, masked writes, busy/done status, and an optional continuous-refresh mode.

Parameters:
- WIDTH, 16: LED count / image width; must be ≥ 1.
- CLK_DIV, 4: clk cycles per half-period of led_clk; must be ≥ 1.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- REFRESH, 0: 0 shifts only after a write or reset; 1 re-shifts continuously.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write strobe for led_in under wmask.
- wmask  in  WIDTH  per-bit write enable; 1 means the bit takes led_in.
- led_in  in  WIDTH  new LED data.
- led_out  out  WIDTH  current LED image register.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame's latch completes.
- led_clk  out  1  serial shift clock; idles low.
- led_pen  out  1  latch strobe (storage clock), active-high pulse.
- led_dat  out  1  serial data.

Behaviour:
- Reset (rst=1 at posedge): led_out=0, busy=0, done=0, led_clk=0, led_pen=0, led_dat=0, state=IDLE.
  - Reset also sets pending=1, so a frame of zeros clears the external chain after release.
  - Reset mid-frame aborts the frame immediately: no led_pen pulse and no done pulse for the aborted frame.
- Image write: when we=1, led_out <= (led_out & ~wmask) | (led_in & wmask). The new value is visible one cycle later.
  - Any we (even with wmask=0) sets pending.
- FSM states: IDLE, LOAD, SHIFT, LATCH.
  - IDLE: if pending, or REFRESH=1, go to LOAD next cycle.
  - LOAD (1 cycle):
    - Snapshot led_out into shadow.
    - Clear pending; a we in this same cycle wins and leaves pending=1.
    - Bit counter = WIDTH-1. busy=1.
  - SHIFT, per bit:
    - led_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - led_dat takes the next shadow bit on entry to the low phase and is stable across the rising edge.
    - Exactly WIDTH rising edges of led_clk per frame.
    - After the last high phase, led_clk returns low; go to LATCH.
  - LATCH: led_pen=1 for CLK_DIV cycles, led_clk=0. Then go to IDLE.
    - In the first IDLE cycle: done=1 and busy=0.
- Frame timing: busy is high for exactly 1 + 2·CLK_DIV·WIDTH + CLK_DIV cycles.
- Writes during a frame: they update led_out but not shadow. The current frame completes unchanged.
  - Multiple writes during one frame produce exactly one follow-up frame, carrying the final led_out.
- REFRESH=1: frames run back-to-back with one IDLE cycle between them. Period is frame length + 1.
- Counters: the bit counter is $clog2(WIDTH) bits, minimum 1. The divider counter is $clog2(CLK_DIV) bits, minimum 1. No wrap occurs beyond the terminal count; terminal-count compares are exact.
- led_dat in IDLE/LATCH holds its last value (0 after reset).

Decomposition:
- Package led_shift_pkg:
  - State enum {IDLE, LOAD, SHIFT, LATCH}.
  - Function frame_cycles(width, div) = 1 + 2·div·width + div, for bench use.
- Sub-module led_serializer (WIDTH, CLK_DIV, MSB_FIRST):
  - Owns shadow, FSM, divider, bit counter and the serial outputs.
  - Handshake: start in (1-cycle pulse), data in, busy/done out.
- Top level led_shift_out owns led_out, wmask logic, pending and the REFRESH policy.

Test Plan (WIDTH=16, CLK_DIV=2 unless stated):
1. Release reset, no writes:
   - One frame follows: 16 led_clk rises, all sampled led_dat=0.
   - One led_pen pulse of 2 cycles.
   - busy high for 67 cycles, then one done pulse; no further frames.
2. we with wmask=FFFF, led_in=A5C3:
   - led_out=A5C3 one cycle later.
   - led_dat sampled at led_clk rises = 1010 0101 1100 0011.
   - With MSB_FIRST=0, the sequence is reversed.
3. Masked write: led_out=A5C3, then wmask=00FF, led_in=1234 → led_out=A534; the next frame shifts A534.
4. During an A5C3 frame at bit 4, write 0F0F and then FFFF:
   - The A5C3 frame completes intact, followed by done.
   - Exactly one further frame follows, shifting FFFF.
5. Assert rst for 1 cycle at bit 5 of a frame:
   - Next cycle: all outputs 0, led_out=0.
   - No led_pen pulse from the aborted frame.
   - A full zero frame follows after release.
6. REFRESH=1, WIDTH=8, CLK_DIV=1, led_out=3C:
   - Continuous frames of 00111100.
   - done pulses every 19 cycles; busy low exactly 1 cycle per period.
